// File: rtl/bht_predictor.sv
// Branch history table predictor: a table of saturating counters indexed
// by fetch PC bits. The optional gshare mode is enabled by defining the
// GSHARE_EN macro. In that mode a global history register is XORed into
// the lookup index.
module bht_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [31:0]           lookup_pc,
  input  logic [6:0]            lookup_opcode,
  output logic                  prediction,
  output logic [INDEX_BITS-1:0] lookup_index,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_taken
);

  localparam int                  ENTRIES    = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX    = {CTR_BITS{1'b1}};
  // Weakly-not-taken: 2^(CTR_BITS-1)-1, i.e. all ones shifted right by one.
  localparam logic [CTR_BITS-1:0] CTR_WNT    = CTR_MAX >> 1;
  localparam logic [6:0]          OPC_BRANCH = 7'b1100011;

  // Saturating step: never wraps at either end of the counter range.
  function automatic logic [CTR_BITS-1:0] sat_step(
    input logic [CTR_BITS-1:0] ctr,
    input logic                taken
  );
    logic [CTR_BITS-1:0] res;
    if (taken) begin
      if (ctr == CTR_MAX) res = ctr;
      else                res = ctr + {{(CTR_BITS-1){1'b0}}, 1'b1};
    end else begin
      if (ctr == {CTR_BITS{1'b0}}) res = ctr;
      else                         res = ctr - {{(CTR_BITS-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  logic [CTR_BITS-1:0]   ctr_table_r [ENTRIES];
  logic [INDEX_BITS-1:0] base_index_s;
  logic [CTR_BITS-1:0]   upd_next_s;
  logic                  upd_we_s;
  logic                  unused_pc_s;

  assign base_index_s = lookup_pc[INDEX_BITS+1:2];
  // PC bits outside the index field carry no information for this table.
  assign unused_pc_s  = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0]};

`ifdef GSHARE_EN
  logic [INDEX_BITS-1:0] history_r;

  // Global outcome history: shifts in each resolved outcome while running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      history_r <= {INDEX_BITS{1'b0}};
    end else if (upd_we_s) begin
      history_r <= {history_r[INDEX_BITS-2:0], update_taken};
    end
  end

  // Lookup index hashes PC bits with the global history.
  always_comb begin
    lookup_index = base_index_s ^ history_r;
  end
`else
  // Lookup index is taken straight from the PC.
  always_comb begin
    lookup_index = base_index_s;
  end
`endif

  // Write qualification and next counter value for the resolving branch.
  always_comb begin
    upd_we_s   = enable & update_valid;
    upd_next_s = sat_step(ctr_table_r[update_index], update_taken);
  end

  // Counter table: reset wins, then at most one entry written per edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_table_r[i] <= CTR_WNT;
      end
    end else if (upd_we_s) begin
      ctr_table_r[update_index] <= upd_next_s;
    end
  end

  // Combinational prediction; reads the table before any same-edge write.
  always_comb begin
    if (lookup_opcode == OPC_BRANCH) begin
      prediction = ctr_table_r[lookup_index][CTR_BITS-1];
    end else begin
      prediction = 1'b0;
    end
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Directed self-checking bench for bht_predictor (default parameters).
module tb_bht_predictor;

  localparam int IB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [31:0]   lookup_pc;
  logic [6:0]    lookup_opcode;
  logic          prediction;
  logic [IB-1:0] lookup_index;
  logic          update_valid;
  logic [IB-1:0] update_index;
  logic          update_taken;

  int            errors = 0;
  int            checks = 0;
  logic [IB-1:0] hist_m = 4'b0000;

  bht_predictor #(.INDEX_BITS(IB), .CTR_BITS(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .lookup_pc    (lookup_pc),
    .lookup_opcode(lookup_opcode),
    .prediction   (prediction),
    .lookup_index (lookup_index),
    .update_valid (update_valid),
    .update_index (update_index),
    .update_taken (update_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; the bench tracks the expected global history itself.
  task automatic tick;
    @(posedge clk);
`ifdef GSHARE_EN
    if (!rst_n) hist_m = 4'b0000;
    else if (enable && update_valid) hist_m = {hist_m[IB-2:0], update_taken};
`endif
    #1;
  endtask

  // Choose a PC that lands on table entry idx under the current history.
  task automatic look(input logic [IB-1:0] idx, input logic [6:0] opc);
    lookup_pc     = 32'h0000_0040 | (32'(idx ^ hist_m) << 2);
    lookup_opcode = opc;
    #1;
  endtask

  task automatic upd(input logic [IB-1:0] idx, input logic taken);
    update_valid = 1'b1;
    update_index = idx;
    update_taken = taken;
    tick();
    update_valid = 1'b0;
  endtask

  initial begin
    // Reset with an update pending: the update must be discarded.
    rst_n = 1'b0; enable = 1'b1; update_valid = 1'b1; update_index = 4'h0;
    update_taken = 1'b1; lookup_pc = 32'h0000_0040; lookup_opcode = 7'h63;
    tick();
    chk("rst_pred", prediction, 32'd0);
    chk("rst_idx", lookup_index, 32'd0);
    for (int i = 0; i < 16; i++) chk("rst_ctr", dut.ctr_table_r[i], 32'd1);

    rst_n = 1'b1; update_valid = 1'b0;
    tick();
    chk("hold_novalid", dut.ctr_table_r[0], 32'd1);

    // Train entry 0 taken up to saturation.
    upd(4'h0, 1'b1); look(4'h0, 7'h63);
    chk("tk1_ctr", dut.ctr_table_r[0], 32'd2);
    chk("tk1_pred", prediction, 32'd1);
    upd(4'h0, 1'b1); look(4'h0, 7'h63);
    chk("tk2_ctr", dut.ctr_table_r[0], 32'd3);
    chk("tk2_pred", prediction, 32'd1);
    for (int i = 0; i < 4; i++) begin
      upd(4'h0, 1'b1);
      chk("sat_hi", dut.ctr_table_r[0], 32'd3);
    end

    // Train back down to saturation at zero.
    upd(4'h0, 1'b0); look(4'h0, 7'h63);
    chk("nt1_pred", prediction, 32'd1);
    chk("nt1_ctr", dut.ctr_table_r[0], 32'd2);
    upd(4'h0, 1'b0); look(4'h0, 7'h63);
    chk("nt2_pred", prediction, 32'd0);
    chk("nt2_ctr", dut.ctr_table_r[0], 32'd1);
    for (int i = 0; i < 3; i++) begin
      upd(4'h0, 1'b0);
      chk("sat_lo", dut.ctr_table_r[0], 32'd0);
    end

    // Same-cycle lookup and update of entry 5: old value, then new.
    look(4'h5, 7'h63);
    update_valid = 1'b1; update_index = 4'h5; update_taken = 1'b1;
    #1;
    chk("rw_old_pred", prediction, 32'd0);
    chk("rw_idx", lookup_index, 32'd5);
    tick();
    update_valid = 1'b0;
    look(4'h5, 7'h63);
    chk("rw_new_pred", prediction, 32'd1);
    chk("rw_ctr5", dut.ctr_table_r[5], 32'd2);
    chk("rw_ctr6", dut.ctr_table_r[6], 32'd1);

    // Stall blocks writes; prediction stays live.
    enable = 1'b0; update_valid = 1'b1; update_index = 4'h2; update_taken = 1'b1;
    repeat (3) tick();
    chk("stall_ctr2", dut.ctr_table_r[2], 32'd1);
    look(4'h2, 7'h63);
    chk("stall_pred2", prediction, 32'd0);
    look(4'h5, 7'h63);
    chk("stall_pred5", prediction, 32'd1);
    enable = 1'b1; update_valid = 1'b0;
    look(4'h5, 7'h33);
    chk("nonbranch", prediction, 32'd0);

    // Reset in the middle of training restores every entry.
    rst_n = 1'b0; update_valid = 1'b1; update_index = 4'h5; update_taken = 1'b1;
    tick();
    rst_n = 1'b1; update_valid = 1'b0;
    for (int i = 0; i < 16; i++) chk("midrst_ctr", dut.ctr_table_r[i], 32'd1);
    look(4'h5, 7'h63);
    chk("midrst_pred", prediction, 32'd0);

`ifdef GSHARE_EN
    chk("hist_rst", dut.history_r, 32'd0);
    upd(4'h0, 1'b1); upd(4'h0, 1'b1); upd(4'h0, 1'b0);
    chk("hist_val", dut.history_r, 32'h6);
    lookup_pc = 32'h0000_0008; #1;
    chk("gshare_idx", lookup_index, 32'h4);
`else
    lookup_pc = 32'h0000_0008; #1;
    chk("plain_idx", lookup_index, 32'h2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 Parameter INDEX_BITS, default 4, log2 of table entry count (16 entries).
REQ-002 Parameter CTR_BITS, default 2, width of each saturating counter; legal range 1..4.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 enable  in  1  stall control; 0 freezes all state (replaces clock gating, no gated clock).
REQ-006 lookup_pc  in  32  fetch-stage PC; bits [INDEX_BITS+1:2] form the base index.
REQ-007 lookup_opcode  in  7  fetch-stage opcode.
REQ-008 prediction  out  1  1 = predict taken.
REQ-009 lookup_index  out  INDEX_BITS  table index used for this lookup; the pipeline carries it to resolve.
REQ-010 update_valid  in  1  a conditional branch resolved this cycle.
REQ-011 update_index  in  INDEX_BITS  lookup_index captured at fetch for the resolving branch.
REQ-012 update_taken  in  1  actual outcome of the resolving branch.

Function
REQ-013 Table SHALL hold 2^INDEX_BITS unsigned counters of CTR_BITS each.
REQ-014 prediction SHALL be combinational: MSB of counter[lookup_index] when lookup_opcode == 7'b1100011, else 0.
REQ-015 Without GSHARE_EN, lookup_index SHALL equal lookup_pc[INDEX_BITS+1:2].
REQ-016 On a rising edge with Reset=1, enable=1, update_valid=1: counter[update_index] SHALL increment if update_taken=1, else decrement.
REQ-017 Counter SHALL saturate at 2^CTR_BITS-1 on increment and at 0 on decrement; no wrap-around.
REQ-018 Update latency SHALL be one cycle: the new counter value is visible to lookups in the cycle after the update edge.
REQ-019 Same-cycle lookup and update to the same index SHALL return the pre-update value (read-before-write, no bypass).
REQ-020 enable=0 SHALL block all counter and history writes regardless of update_valid; prediction stays combinationally valid.
REQ-021 Only one entry SHALL change per cycle; all other entries hold.
REQ-022 update_valid=0 SHALL leave all state unchanged.

Reset
REQ-023 With Reset=0 at a rising edge, every counter SHALL load weakly-not-taken, 2^(CTR_BITS-1)-1 (01 for CTR_BITS=2; 0 for CTR_BITS=1).
REQ-024 Reset SHALL take priority over enable and update_valid; an update presented in a reset cycle is discarded.
REQ-025 The global history register (when present) SHALL reset to all zeros.
REQ-026 After reset, prediction SHALL be 0 for every PC until an entry is trained.
REQ-027 Reset asserted mid-training SHALL restore every entry to weakly-not-taken on that edge; no partial state survives.

Configuration
REQ-028 Macro GSHARE_EN defined: an INDEX_BITS-wide global history register SHALL exist; lookup_index = lookup_pc[INDEX_BITS+1:2] XOR history.
REQ-029 With GSHARE_EN, on each enabled update edge history SHALL shift left by one, inserting update_taken at bit 0; the counter update uses update_index unchanged.
REQ-030 Macro GSHARE_EN undefined: no history register is instantiated; indexing per REQ-015.

Verification
REQ-031 Reset low 1 cycle, lookup_pc=0x40, opcode=0x63 -> prediction=0, lookup_index=0x0.
REQ-032 Index 0x0 (from pc 0x40): two taken updates -> prediction=1 next cycle; four further taken updates -> counter stays 3 (saturated).
REQ-033 From counter 3, one not-taken update -> prediction still 1; second not-taken -> prediction=0; three more -> counter stays 0.
REQ-034 Update index 0x5 taken while looking up pc=0x14 (index 0x5) in the same cycle -> prediction shows old value that cycle, new value next cycle; entry 0x6 unchanged.
REQ-035 enable=0 with 3 taken updates to index 0x2 -> counter stays 1; opcode=0x33 with trained taken entry -> prediction=0.
REQ-036 GSHARE_EN defined: updates taken,taken,not-taken -> history=3'b110 (INDEX_BITS=4: 4'b0110); lookup_pc=0x08 -> lookup_index=0x2^0x6=0x4.
